// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: sequences the shared multi-precision adder to compute
// (a+b) mod m or (a-b) mod m using one or two adder passes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands are latched when start is accepted
// S1    | pass-1 add_start is high (raw a+b or a-b)
// W1    | waiting for pass-1 add_done, guarded by the timeout counter
// S2    | pass-2 add_start is high (correction r-m or r+m)
// W2    | waiting for pass-2 add_done, guarded by the timeout counter
// FIN   | final residue and error flag are transferred to the outputs
//
// Every output is a flop. The adder controls (add_start, add_a, add_b,
// add_subtract) are loaded on the edge that enters S1/S2, so they are high
// or valid during the S-state itself. result/done/err are loaded on the
// edge that leaves FIN, so done is seen the cycle after FIN.
module mod_addsub_ctrl #(
    parameter int N       = 1027,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         err,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N:0]   add_result,
    input  logic         add_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        W1   = 3'd2,
        S2   = 3'd3,
        W2   = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t          state, state_d;

    // Operation context latched at start.
    logic [N-1:0]    m_q, m_d;
    logic            op_q, op_d;

    // Pass-1 result, final residue and error flag pending for FIN.
    logic [N-1:0]    r_q, r_d;
    logic [N-1:0]    fin_q, fin_d;
    logic            ferr_q, ferr_d;

    logic [CW-1:0]   cnt_q, cnt_d;

    // Next values of the registered outputs.
    logic [N-1:0]    result_d;
    logic            done_d;
    logic            err_d;
    logic            busy_d;
    logic            add_start_d;
    logic            add_subtract_d;
    logic [N-1:0]    add_a_d;
    logic [N-1:0]    add_b_d;

    logic            timeout_hit;
    logic [N-1:0]    sum_lo;
    logic            sum_carry;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign sum_lo      = add_result[N-1:0];
    assign sum_carry   = add_result[N];

    // State register and all datapath/output flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            m_q          <= '0;
            op_q         <= 1'b0;
            r_q          <= '0;
            fin_q        <= '0;
            ferr_q       <= 1'b0;
            cnt_q        <= '0;
            result       <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
        end else begin
            state        <= state_d;
            m_q          <= m_d;
            op_q         <= op_d;
            r_q          <= r_d;
            fin_q        <= fin_d;
            ferr_q       <= ferr_d;
            cnt_q        <= cnt_d;
            result       <= result_d;
            done         <= done_d;
            err          <= err_d;
            busy         <= busy_d;
            add_start    <= add_start_d;
            add_subtract <= add_subtract_d;
            add_a        <= add_a_d;
            add_b        <= add_b_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state
    // below says otherwise, and add_start/done/err default to a single pulse.
    always_comb begin
        state_d        = state;
        m_d            = m_q;
        op_d           = op_q;
        r_d            = r_q;
        fin_d          = fin_q;
        ferr_d         = ferr_q;
        cnt_d          = cnt_q;
        result_d       = result;
        done_d         = 1'b0;
        err_d          = 1'b0;
        add_start_d    = 1'b0;
        add_subtract_d = add_subtract;
        add_a_d        = add_a;
        add_b_d        = add_b;

        unique case (state)
            IDLE: begin
                if (start) begin
                    m_d            = in_m;
                    op_d           = op;
                    ferr_d         = 1'b0;
                    add_start_d    = 1'b1;
                    add_a_d        = in_a;
                    add_b_d        = in_b;
                    add_subtract_d = op;
                    state_d        = S1;
                end
            end

            S1: begin
                cnt_d   = '0;
                state_d = W1;
            end

            W1: begin
                if (add_done) begin
                    r_d = sum_lo;
                    if (op_q && sum_carry) begin
                        // a >= b: the raw difference is already reduced.
                        fin_d   = sum_lo;
                        state_d = FIN;
                    end else begin
                        // Sum needs r-m trial, or negative difference needs +m.
                        add_start_d    = 1'b1;
                        add_a_d        = sum_lo;
                        add_b_d        = m_q;
                        add_subtract_d = ~op_q;
                        state_d        = S2;
                    end
                end else if (timeout_hit) begin
                    fin_d   = '0;
                    ferr_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S2: begin
                cnt_d   = '0;
                state_d = W2;
            end

            W2: begin
                if (add_done) begin
                    if (!op_q) begin
                        // Carry set means no borrow, i.e. r >= m: keep r-m.
                        fin_d = sum_carry ? sum_lo : r_q;
                    end else begin
                        // r+m wraps modulo 2^N back into range; carry is don't-care.
                        fin_d = sum_lo;
                    end
                    state_d = FIN;
                end else if (timeout_hit) begin
                    fin_d   = '0;
                    ferr_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            FIN: begin
                result_d = fin_q;
                done_d   = 1'b1;
                err_d    = ferr_q;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy covers S1..FIN plus the cycle where done is visible.
        busy_d = (state_d != IDLE) || (state == FIN);
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: behavioural adder with fixed latency, a
// reference modular model and a scoreboard of expected completions.
module tb_mod_addsub_ctrl;

    localparam int N  = 1027;
    localparam int TO = 16;
    localparam int L  = 5;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         op;
    logic [N-1:0] in_a, in_b, in_m;
    logic [N-1:0] result;
    logic         done, err, busy;
    logic         add_start, add_subtract;
    logic [N-1:0] add_a, add_b;
    logic [N:0]   add_result;
    logic         add_done;

    mod_addsub_ctrl #(.N(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .op           (op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic         err;
        int           lat;
        int           starts;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_starts = 0;
    int n_consec = 0;

    // Adder model state.
    int         pend = 0;
    logic [N:0] pend_res;
    logic       prev_start = 1'b0;
    bit         mdl_no_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder: add_done is high exactly L cycles after add_start.
    always @(negedge clk) begin
        add_done = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0 && !mdl_no_done) begin
                add_done   = 1'b1;
                add_result = pend_res;
            end
        end
        if (add_start) begin
            pend = L;
            if (add_subtract)
                pend_res = {1'b0, add_a} + {1'b0, ~add_b} + (N+1)'(1);
            else
                pend_res = {1'b0, add_a} + {1'b0, add_b};
            n_starts = n_starts + 1;
            if (prev_start) n_consec = n_consec + 1;
        end
        prev_start = add_start;
        if (done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_mod(input logic o, input logic [N-1:0] a,
                                             input logic [N-1:0] b, input logic [N-1:0] m);
        logic [N:0] t;
        if (!o) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[N-1:0];
    endfunction

    task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input bit poke, input bit to);
        exp_t e;
        exp_t g;
        int   s;
        int   d0;
        bit   got;
        bit   one;
        one = o && (a >= b);
        if (to) begin
            e.res = '0; e.err = 1'b1; e.lat = 3 + TO; e.starts = 1;
        end else begin
            e.res = ref_mod(o, a, b, m); e.err = 1'b0;
            e.lat = one ? (3 + L) : (4 + 2 * L);
            e.starts = one ? 1 : 2;
        end
        sb.push_back(e);

        @(negedge clk);
        s = cyc;
        n_starts = 0;
        start = 1'b1; op = o; in_a = a; in_b = b; in_m = m;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            start = poke && (cyc - s == 4);
            if (start) begin
                op = ~o; in_a = ~a; in_b = ~b; in_m = ~m;
            end
            if (done) begin
                got = 1'b1;
                g = sb.pop_front();
                chk("result", result, g.res);
                chk("err", err, g.err);
                chk("latency", cyc - s, g.lat);
                chk("add_starts", n_starts, g.starts);
                chk("start_consec", n_consec, 0);
                chk("busy_at_done", busy, 1'b1);
            end
        end
        if (!got) begin
            chk("done_seen", 0, 1);
            void'(sb.pop_front());
        end
        start = 1'b0;
        @(negedge clk);
        chk("busy_after", busy, 1'b0);
        if (poke) begin
            d0 = n_done;
            repeat (20) @(negedge clk);
            chk("ignored_start_no_done", n_done - d0, 0);
            chk("result_held", result, e.res);
        end
    endtask

    logic [N-1:0] fw_m, fw_a;
    int           s0, d1;

    initial begin
        resetn = 1'b0; start = 1'b0; op = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        add_result = '0; add_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_start", add_start, 0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(1'b0, 5, 7, 11, 1'b0, 1'b0);
        run_op(1'b0, 3, 4, 11, 1'b0, 1'b0);
        run_op(1'b0, 6, 5, 11, 1'b0, 1'b0);
        run_op(1'b1, 9, 4, 11, 1'b0, 1'b0);
        run_op(1'b1, 3, 7, 11, 1'b0, 1'b0);
        run_op(1'b1, 7, 7, 11, 1'b0, 1'b0);

        fw_m = '0;
        fw_m[N-1] = 1'b1;
        fw_m = fw_m - 1'b1;
        fw_a = fw_m - 1'b1;
        run_op(1'b0, fw_a, fw_a, fw_m, 1'b1, 1'b0);
        run_op(1'b1, '0, fw_a, fw_m, 1'b0, 1'b0);

        mdl_no_done = 1'b1;
        run_op(1'b0, 5, 7, 11, 1'b0, 1'b1);
        mdl_no_done = 1'b0;
        run_op(1'b0, 2, 6, 11, 1'b0, 1'b0);

        // Reset in the middle of the second pass.
        @(negedge clk);
        s0 = cyc;
        start = 1'b1; op = 1'b0; in_a = 5; in_b = 7; in_m = 11;
        @(negedge clk);
        start = 1'b0;
        while (cyc - s0 < 10) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("arst_result", result, '0);
        chk("arst_busy", busy, 0);
        chk("arst_add_a", add_a, '0);
        chk("arst_add_b", add_b, '0);
        chk("arst_add_subtract", add_subtract, 0);
        chk("arst_done_err", {done, err, add_start}, 0);
        d1 = n_done;
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("late_add_done_ignored", n_done - d1, 0);
        chk("late_busy", busy, 0);
        run_op(1'b0, 1, 2, 11, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mod_addsub_ctrl.md
Name: mod_addsub_ctrl

Overview:
- Sequences the shared multi-precision adder/subtractor (`mpadder`) to compute modular addition `(a+b) mod m` or modular subtraction `(a-b) mod m`.
- Runs one or two adder passes per operation:
  - first pass: raw add or subtract;
  - second pass: correction by `m`, applied only when needed.
- Sits between the Montgomery/exponentiation top-level FSM and the adder instance; owns the adder's start/operand/subtract inputs exclusively.

Parameters:
- `N`, 1027, operand width in bits (adder operand width; adder result width is N+1).
- `TIMEOUT`, 16, maximum cycles to wait for `add_done` after an `add_start` pulse before aborting.

Ports:
- `clk`  input  1  system clock, rising edge.
- `resetn`  input  1  reset, asynchronous, active-low.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `op`  input  1  0 = modular add, 1 = modular subtract; sampled with `start`.
- `in_a`  input  N  operand a; precondition a < m.
- `in_b`  input  N  operand b; precondition b < m.
- `in_m`  input  N  modulus; precondition m < 2^(N-1).
- `result`  output  N  final residue; held until next accepted start.
- `done`  output  1  one-cycle pulse when `result` is valid.
- `err`  output  1  one-cycle pulse, coincident with `done`, on adder timeout.
- `busy`  output  1  high from the cycle after accepted start through the `done` cycle.
- `add_start`  output  1  start pulse to the adder.
- `add_subtract`  output  1  0 = a+b, 1 = a-b (a + ~b + 1).
- `add_a`  output  N  adder operand a.
- `add_b`  output  N  adder operand b.
- `add_result`  input  N+1  adder result; bit N is the carry. After subtract, bit N = 1 means no borrow.
- `add_done`  input  1  adder completion pulse.

Behaviour:
- Reset (async, `resetn`=0): state IDLE; all registers 0; outputs `result`, `done`, `err`, `busy`, `add_start`, `add_subtract`, `add_a`, `add_b` all 0. Applies mid-operation too; any in-flight adder result is discarded.
- All outputs are registered.
- States: IDLE, S1, W1, S2, W2, FIN.
- IDLE:
  - `start`=1 latches a, b, m, op; next state S1.
  - `start` in any other state is ignored (no queueing).
- S1 (one cycle):
  - `add_start`=1, `add_a`=a, `add_b`=b, `add_subtract`=op.
  - Clear the timeout counter; next state W1.
- W1:
  - Counter increments each cycle.
  - On `add_done`: capture r = `add_result[N-1:0]` and c = `add_result[N]`.
    - op=0: next state S2.
    - op=1 and c=1 (a≥b): final = r, go FIN (single pass).
    - op=1 and c=0: next state S2.
  - Counter reaching TIMEOUT with no `add_done`: go FIN with err=1 and final = 0.
- S2 (one cycle):
  - `add_start`=1, `add_a`=r, `add_b`=m.
  - `add_subtract`=1 for op=0 (r-m); `add_subtract`=0 for op=1 (r+m).
  - Clear the counter; next state W2.
- W2:
  - On `add_done`:
    - op=0: final = `add_result[N-1:0]` if `add_result[N]`=1 (r≥m), else final = r.
    - op=1: final = `add_result[N-1:0]`; the carry is ignored.
    - Next state FIN.
  - Same timeout rule as W1.
- FIN (one cycle):
  - `result` ← final, `done`=1, `err` as flagged.
  - Next state IDLE; `busy` drops the following cycle.
- `add_a`, `add_b`, `add_subtract` hold stable from the S-state until the next S-state or reset.
- `add_start` is never high two consecutive cycles.
- `add_done` seen outside W1/W2 is ignored.
- Latency with adder start-to-done latency L (cycles from `add_start` high to `add_done` high):
  - `done` = 1 + 1 + L + 1 + L + 1 cycles after `start` for two passes.
  - `done` = 1 + 1 + L + 1 cycles after `start` for one pass.
- Width rule: since a, b < m < 2^(N-1), a+b fits in N bits; the pass-1 carry is unused for op=0.

Test Plan:
- Adder model with L=5. op=0, a=5, b=7, m=11 → `result`=1, two `add_start` pulses, `done` at cycle 14, `err`=0.
- op=0, a=3, b=4, m=11 → `result`=7 (second pass borrows, r kept); a=6, b=5, m=11 → `result`=0 (exact m boundary).
- op=1, a=9, b=4, m=11 → `result`=5, exactly one `add_start`, `done` at cycle 8; op=1, a=3, b=7, m=11 → `result`=7, two passes.
- Full width: op=0, a=b=2^(N-1)-2, m=2^(N-1)-1 → `result`=2^(N-1)-3. `start` pulsed while `busy` → ignored, result unchanged.
- Adder model never asserts `add_done` → `done`=`err`=1 at the 16th W1 cycle, `result`=0, `busy` low next cycle, next op runs normally.
- Assert `resetn`=0 during W2 → all outputs 0 immediately (async); after release, a late `add_done` is ignored and a new op=0, a=1, b=2, m=11 returns 3.
